// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
//   funct3_e  : RV32I load/store width encodings
//   state_e   : responder FSM states (legacy two-bit encodings kept as localparams)
//   is_reserved / is_misaligned : request classification helpers
package mem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } funct3_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    RESP = ST_RESP
  } state_e;

  // Loads reserve 011/110/111; stores only define B/H/W.
  function automatic logic is_reserved(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 >= 3'b011);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      MEM_H, MEM_HU: return addr_lo[0];
      MEM_W:         return (addr_lo != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a datapath (master) and the data-memory responder (slave).
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_funct3 : request channel
//   resp_valid/resp_ready/resp_rdata/resp_err               : response channel
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder_lsu_align.sv
// lsu_align: combinational byte-lane steering for the data-memory responder.
//   funct3     in  3   access width / signedness
//   addr_lo    in  2   byte offset within the word
//   wdata      in  32  raw store data
//   rword      in  32  addressed memory word
//   be         out 4   store byte enables (0 for reserved widths)
//   wdata_lane out 32  store data replicated onto every candidate lane
//   rdata_ext  out 32  selected load lane, sign- or zero-extended
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = '0;
    wdata_lane = wdata;
    rdata_ext  = '0;
    byte_sel   = rword[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? rword[31:16] : rword[15:0];
    // funct3[2] distinguishes the unsigned load variants.
    case (funct3)
      MEM_B, MEM_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{byte_sel[7] & ~funct3[2]}}, byte_sel};
      end
      MEM_H, MEM_HU: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{half_sel[15] & ~funct3[2]}}, half_sel};
      end
      MEM_W: begin
        be         = '1;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory serving RV32I loads/stores.
//   clk  in    clock, rising edge
//   rst  in    synchronous active-high reset
//   bus  slave request/response bus (see data_mem_responder_if)
// Parameters: DEPTH_WORDS (word count, address wraps), LATENCY (1..15 cycles
// from accept to resp_valid), INIT_FILE (optional init image name).
// Build option: define MISALIGN_TRAP_EN to reject misaligned H/W accesses.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e        state;
  logic [3:0]    cnt;
  logic          a_we;
  logic [AW+1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [2:0]    a_funct3;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rext;
  logic          req_err;
  logic          commit;
  logic          unused_addr;

  assign unused_addr = ^bus.req_addr[31:AW+2];

  assign idx    = a_addr[AW+1:2];
  assign rword  = mem[idx];
  assign commit = (state == WAIT) && (cnt == '0);

`ifdef MISALIGN_TRAP_EN
  assign req_err = is_reserved(a_we, a_funct3) | is_misaligned(a_funct3, a_addr[1:0]);
`else
  assign req_err = is_reserved(a_we, a_funct3);
`endif

  lsu_align u_align (
    .funct3     (a_funct3),
    .addr_lo    (a_addr[1:0]),
    .wdata      (a_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wlane),
    .rdata_ext  (rext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      a_we     <= 1'b0;
      a_addr   <= '0;
      a_wdata  <= '0;
      a_funct3 <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          a_we     <= bus.req_we;
          a_addr   <= bus.req_addr[AW+1:0];
          a_wdata  <= bus.req_wdata;
          a_funct3 <= bus.req_funct3;
          cnt      <= 4'(LATENCY - 1);
          state    <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          rdata_q <= (a_we || req_err) ? '0 : rext;
          err_q   <= req_err;
          state   <= RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP: if (bus.resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write only on the WAIT->RESP edge; a reset on that same edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && commit && a_we && !req_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int unsigned LAT = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (LAT),
    .INIT_FILE   ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic void add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, input logic [31:0] rd, input logic err);
    vecs.push_back('{we, addr, wdata, f3, rd, err});
  endfunction

  // Scoreboard: compare on every response handshake (sampled mid-cycle).
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", 64'(bus.resp_rdata), 64'(e.rd));
        chk("resp_err", 64'(bus.resp_err), 64'(e.err));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the response retired.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", 64'(n < 50), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_funct3 = v.f3;
    sb.push_back('{rd: v.rd, err: v.err});
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom);
    n = 0;
    while (!bus.resp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'(LAT));
    chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    chk("resp_retired", 64'(bus.resp_valid), 64'd0);
    chk("req_ready_after", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    logic [31:0] bp_exp;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    bus.resp_ready = 1'b1;
    rst            = 1'b1;

    add(1, 32'h100,  32'hDEADBEEF, 3'b010, 32'h0,        0);
    add(0, 32'h100,  32'h0,        3'b010, 32'hDEADBEEF, 0);
    add(0, 32'h103,  32'h0,        3'b000, 32'hFFFFFFDE, 0);
    add(0, 32'h103,  32'h0,        3'b100, 32'h000000DE, 0);
    add(0, 32'h102,  32'h0,        3'b001, 32'hFFFFDEAD, 0);
    add(0, 32'h100,  32'h0,        3'b101, 32'h0000BEEF, 0);
    add(1, 32'h101,  32'hFFFFFF12, 3'b000, 32'h0,        0);
    add(0, 32'h100,  32'h0,        3'b010, 32'hDEAD12EF, 0);
    add(1, 32'h102,  32'hABCD5566, 3'b001, 32'h0,        0);
    add(0, 32'h100,  32'h0,        3'b010, 32'h556612EF, 0);
    add(0, 32'h101,  32'h0,        3'b000, 32'h00000012, 0);
    add(0, 32'h100,  32'h0,        3'b000, 32'hFFFFFFEF, 0);
    add(0, 32'h102,  32'h0,        3'b101, 32'h00005566, 0);
    add(0, 32'h102,  32'h0,        3'b001, 32'h00005566, 0);
    add(0, 32'h100,  32'h0,        3'b011, 32'h0,        1);
    add(0, 32'h100,  32'h0,        3'b110, 32'h0,        1);
    add(1, 32'h100,  32'hFFFFFFFF, 3'b011, 32'h0,        1);
    add(1, 32'h100,  32'h0,        3'b100, 32'h0,        1);
    add(0, 32'h100,  32'h0,        3'b010, 32'h556612EF, 0);
    add(1, 32'h104,  32'h01234567, 3'b010, 32'h0,        0);
    add(0, 32'h1104, 32'h0,        3'b010, 32'h01234567, 0);
    add(1, 32'h200,  32'h11112222, 3'b010, 32'h0,        0);
    add(0, 32'h102,  32'h0,        3'b010, TRAP ? 32'h0 : 32'h556612EF, TRAP);
    add(1, 32'h102,  32'hAAAAAAAA, 3'b010, 32'h0, TRAP);
    add(0, 32'h100,  32'h0,        3'b010, TRAP ? 32'h556612EF : 32'hAAAAAAAA, 0);
    add(0, 32'h101,  32'h0,        3'b001, TRAP ? 32'h0 : 32'hFFFFAAAA, TRAP);
    bp_exp = TRAP ? 32'h556612EF : 32'hAAAAAAAA;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) send(vecs[i]);

    // Back-pressure: hold the response, keep a second request pending behind it.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h100;
    bus.req_funct3 = 3'b010;
    sb.push_back('{rd: bp_exp, err: 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_latency", 64'(n), 64'(LAT));
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h104;
        bus.req_funct3 = 3'b010;
        sb.push_back('{rd: 32'h01234567, err: 1'b0});
      end
      @(posedge clk); #1;
      chk("bp_valid_held", 64'(bus.resp_valid), 64'd1);
      chk("bp_rdata_held", 64'(bus.resp_rdata), 64'(bp_exp));
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_retire_valid", 64'(bus.resp_valid), 64'd0);
    chk("bp_no_accept_on_retire", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_accept_next", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("bp2_latency", 64'(n), 64'(LAT));
    @(posedge clk); #1;
    chk("bp2_idle", 64'(bus.req_ready), 64'd1);

    // Reset during WAIT of a store: the store must not land.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h200;
    bus.req_wdata  = 32'hCAFEF00D;
    bus.req_funct3 = 3'b010;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("midrst_accepted", 64'(bus.req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    chk("midrst_resp_err", 64'(bus.resp_err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(bus.req_ready), 64'd1);
    send('{1'b0, 32'h200, 32'h0, 3'b010, 32'h11112222, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
